uart_tx_frame: RTL

//  Transmit datapath of the debug UART. Generates the free-running baud divider (fr_div) and
//  the bits-remaining counter (CNT) that the TX ready handshake stage consumes, and serialises
//  one byte per accepted handshake onto txd: start bit, 8 data bits LSB first, optional parity,

---
 rtl/uart_tx_frame.sv | 84 ++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// Debug UART transmit datapath: free-running baud divider plus a start/data/[parity]/stop
// serialiser whose bits-remaining count (CNT) feeds the TX ready handshake stage.
module uart_tx_frame #(
    parameter int unsigned DIV    = 10416,
    parameter int unsigned PARITY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld_tx,
    input  logic        rdy_tx,
    input  logic [7:0]  d_tx,
    output logic [15:0] fr_div,
    output logic [3:0]  CNT,
    output logic        txd,
    output logic        busy
);

    localparam int unsigned SW       = (PARITY == 0) ? 9 : 10;
    localparam logic [3:0]  CNT_LOAD = (PARITY == 0) ? 4'd9 : 4'd10;
    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    logic [15:0]   fr_div_q, fr_div_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic [SW-1:0] shift_q, shift_d;
    logic [9:0]    shift_load;
    logic          tick;
    logic          accept;
    logic          par;

    // Handshake: a byte is taken only on a bit tick where vld_tx and rdy_tx are both high;
    // d_tx is sampled on that tick alone, and neither side may assume a transfer otherwise.
    always_comb begin
        tick     = (fr_div_q == 16'd0);
        accept   = tick && vld_tx && rdy_tx;
        par      = (PARITY == 2) ? ~^d_tx : ^d_tx;
        fr_div_d = (fr_div_q == DIV_LAST) ? 16'd0 : fr_div_q + 16'd1;

        // With no parity the extra field is a second stop-level 1 that the slice drops.
        shift_load = {1'b1, (PARITY == 0) ? 1'b1 : par, d_tx};

        txd_d   = txd_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;

        // A forced accept mid-frame deliberately aborts the frame in flight.
        if (accept) begin
            txd_d   = 1'b0;
            cnt_d   = CNT_LOAD;
            shift_d = shift_load[SW-1:0];
        end else if (tick && cnt_q != 4'd0) begin
            txd_d   = shift_q[0];
            shift_d = {1'b1, shift_q[SW-1:1]};
            cnt_d   = cnt_q - 4'd1;
        end else if (tick) begin
            txd_d = 1'b1;
        end

        busy_d = (cnt_d != 4'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fr_div_q <= 16'd0;
            cnt_q    <= 4'd0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            shift_q  <= '1;
        end else begin
            fr_div_q <= fr_div_d;
            cnt_q    <= cnt_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            shift_q  <= shift_d;
        end
    end

    assign fr_div = fr_div_q;
    assign CNT    = cnt_q;
    assign txd    = txd_q;
    assign busy   = busy_q;

endmodule
